// File: rtl/sobel_pkg.sv
// Shared state encoding and pixel/colour constants for the Sobel front-end streamer.
// Grey coefficients sum to 256, so the top byte of the weighted sum is the grey level.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  localparam int PIX_W  = 8;
  localparam int RGB_W  = 24;
  localparam int SUM_W  = 16;
  localparam int GAP_W  = 4;

  localparam int COEF_R = 77;
  localparam int COEF_G = 150;
  localparam int COEF_B = 29;

endpackage

// File: rtl/sobel_frame_streamer_if.sv
// Frame-memory read port plus grey pixel stream of the Sobel front-end streamer.
// The master side is the streamer; the slave side is memory and downstream buffer.
interface sobel_frame_streamer_if #(
  parameter int ADDR_W = 16
);

  logic              start_i;
  logic              hold_i;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [23:0]       mem_data_i;
  logic [7:0]        grey_o;
  logic              done_o;
  logic              line_end_o;
  logic              busy_o;
  logic              frame_done_o;

  modport master (
    input  start_i,
    input  hold_i,
    input  mem_data_i,
    output mem_rd_o,
    output mem_addr_o,
    output grey_o,
    output done_o,
    output line_end_o,
    output busy_o,
    output frame_done_o
  );

  modport slave (
    output start_i,
    output hold_i,
    output mem_data_i,
    input  mem_rd_o,
    input  mem_addr_o,
    input  grey_o,
    input  done_o,
    input  line_end_o,
    input  busy_o,
    input  frame_done_o
  );

endinterface

// File: rtl/rgb2grey_pipe.sv
// RGB to grey converter: weighted sum of the incoming word, top byte registered with its valid.
// grey_o keeps the last converted value while valid_o is low.
module rgb2grey_pipe
  import sobel_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RGB_W-1:0] rgb_i,
  input  logic             valid_i,
  output logic [PIX_W-1:0] grey_o,
  output logic             valid_o
);

  logic [SUM_W-1:0] sum_d;
  logic [PIX_W-1:0] grey_q;
  logic             valid_q;

  // Maximum sum is 256*255 = 65280, so 16 bits never overflow.
  always_comb begin
    sum_d = SUM_W'(COEF_R) * SUM_W'(rgb_i[23:16])
          + SUM_W'(COEF_G) * SUM_W'(rgb_i[15:8])
          + SUM_W'(COEF_B) * SUM_W'(rgb_i[7:0]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grey_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        grey_q <= PIX_W'(sum_d >> PIX_W);
      end
    end
  end

  assign grey_o  = grey_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/sobel_frame_streamer.sv
// Walks an RGB frame in synchronous-read memory in raster order and streams grey pixels
// with a one-cycle done strobe, row-end marker and end-of-frame pulse.
module sobel_frame_streamer
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int GAP    = 0
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_i,
  sobel_frame_streamer_if.master bus
);

  localparam int                COL_W     = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              drain_q, drain_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              rd;
  logic              rd_q;
  logic [PIX_W-1:0]  grey;
  logic              done;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      gap_q   <= '0;
      drain_q <= 1'b0;
      col_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      drain_q <= drain_d;
      col_q   <= col_d;
      rd_q    <= rd;
    end
  end

  // DRAIN lasts two cycles: the last word's memory cycle, then its conversion cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    drain_d = drain_q;
    rd      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          addr_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!bus.hold_i) begin
          rd      = 1'b1;
          addr_d  = addr_q + 1'b1;
          gap_d   = '0;
          drain_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else if (GAP > 0) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_READ;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rd_q marks the cycle in which the memory word for the previous read is on mem_data_i.
  rgb2grey_pipe u_pipe (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .rgb_i   (bus.mem_data_i),
    .valid_i (rd_q),
    .grey_o  (grey),
    .valid_o (done)
  );

  always_comb begin
    col_d = col_q;
    if (done) begin
      col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
    end
  end

  assign bus.mem_rd_o     = rd;
  assign bus.mem_addr_o   = addr_q;
  assign bus.grey_o       = grey;
  assign bus.done_o       = done;
  assign bus.line_end_o   = done && (col_q == LAST_COL);
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.frame_done_o = done && (state_q == ST_DRAIN) && drain_q;

endmodule

// File: tb/tb_sobel_frame_streamer.sv
// Directed bench for sobel_frame_streamer on a 4x3 frame, one instance with GAP=0 and one with GAP=2.
// Memory words replicate the address into R, G and B, so the expected grey equals the address.
module tb_sobel_frame_streamer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 16;

  typedef struct {
    int start;
    int hold;
    int rd;
    int addr;
    int done;
    int grey;
    int lineEnd;
    int frameDone;
    int busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] mem [0:15];

  sobel_frame_streamer_if #(.ADDR_W(ADDR_W)) bus0 ();
  sobel_frame_streamer_if #(.ADDR_W(ADDR_W)) bus2 ();

  sobel_frame_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .GAP(0)) dut0 (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bus0)
  );

  sobel_frame_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .GAP(2)) dut2 (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus0.mem_rd_o) bus0.mem_data_i <= mem[bus0.mem_addr_o[3:0]];
    if (bus2.mem_rd_o) bus2.mem_data_i <= mem[bus2.mem_addr_o[3:0]];
  end

  function automatic vec_t mk(int s, int h, int rd, int addr, int dn, int gr, int le, int fd, int bz);
    vec_t v;
    v.start = s; v.hold = h; v.rd = rd; v.addr = addr; v.done = dn;
    v.grey = gr; v.lineEnd = le; v.frameDone = fd; v.busy = bz;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One cycle on dut0: drive just after the rising edge, return at the falling edge for sampling.
  task automatic applyStimulus(input int start, input int hold);
    @(posedge clk);
    #1;
    bus0.start_i = 1'(start);
    bus0.hold_i  = 1'(hold);
    @(negedge clk);
  endtask

  task automatic waitFrameDone(input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < 60 && seen == 0; c++) begin
      applyStimulus(0, 0);
      if (bus0.frame_done_o) seen = 1;
    end
    checkOutput(name, seen, 1);
  endtask

  initial begin
    vec_t tbl[17];
    int   colourGrey[4];
    int   rdAddrs[$];
    int   greys[$];
    int   doneCnt;
    int   fdCnt;

    for (int i = 0; i < 16; i++) mem[i] = {3{8'(i)}};
    bus0.start_i = 1'b0; bus0.hold_i = 1'b0;
    bus2.start_i = 1'b0; bus2.hold_i = 1'b0;

    // k=0 start; reads k=1..12; done k=3..14; line ends 6,10,14; frame done 14; busy 1..14.
    tbl[0]  = mk(1, 0, 0, 0,  0, 0,  0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0,  0, 0,  0, 0, 1);
    tbl[2]  = mk(0, 0, 1, 1,  0, 0,  0, 0, 1);
    tbl[3]  = mk(0, 0, 1, 2,  1, 0,  0, 0, 1);
    tbl[4]  = mk(0, 0, 1, 3,  1, 1,  0, 0, 1);
    tbl[5]  = mk(0, 0, 1, 4,  1, 2,  0, 0, 1);
    tbl[6]  = mk(0, 0, 1, 5,  1, 3,  1, 0, 1);
    tbl[7]  = mk(0, 0, 1, 6,  1, 4,  0, 0, 1);
    tbl[8]  = mk(0, 0, 1, 7,  1, 5,  0, 0, 1);
    tbl[9]  = mk(0, 0, 1, 8,  1, 6,  0, 0, 1);
    tbl[10] = mk(0, 0, 1, 9,  1, 7,  1, 0, 1);
    tbl[11] = mk(0, 0, 1, 10, 1, 8,  0, 0, 1);
    tbl[12] = mk(0, 0, 1, 11, 1, 9,  0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0,  1, 10, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0,  1, 11, 1, 1, 1);
    tbl[15] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0);
    colourGrey = '{255, 76, 149, 28};

    #2;
    checkOutput("rst_mem_rd", bus0.mem_rd_o, 0);
    checkOutput("rst_mem_addr", int'(bus0.mem_addr_o), 0);
    checkOutput("rst_grey", int'(bus0.grey_o), 0);
    checkOutput("rst_done", bus0.done_o, 0);
    checkOutput("rst_line_end", bus0.line_end_o, 0);
    checkOutput("rst_busy", bus0.busy_o, 0);
    checkOutput("rst_frame_done", bus0.frame_done_o, 0);
    checkOutput("rst_busy_gap2", bus2.busy_o, 0);
    #10 rst = 1'b0;

    $display("[TB] full frame table, GAP=0");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].start, tbl[i].hold);
      checkOutput($sformatf("tbl%0d_rd", i), bus0.mem_rd_o, tbl[i].rd);
      if (tbl[i].rd != 0) checkOutput($sformatf("tbl%0d_addr", i), int'(bus0.mem_addr_o), tbl[i].addr);
      checkOutput($sformatf("tbl%0d_done", i), bus0.done_o, tbl[i].done);
      if (tbl[i].done != 0) checkOutput($sformatf("tbl%0d_grey", i), int'(bus0.grey_o), tbl[i].grey);
      checkOutput($sformatf("tbl%0d_line_end", i), bus0.line_end_o, tbl[i].lineEnd);
      checkOutput($sformatf("tbl%0d_frame_done", i), bus0.frame_done_o, tbl[i].frameDone);
      checkOutput($sformatf("tbl%0d_busy", i), bus0.busy_o, tbl[i].busy);
    end

    $display("[TB] colour conversion");
    mem[0] = 24'hFFFFFF; mem[1] = 24'hFF0000; mem[2] = 24'h00FF00; mem[3] = 24'h0000FF;
    for (int k = 0; k <= 6; k++) begin
      applyStimulus(k == 0 ? 1 : 0, 0);
      if (k >= 3) begin
        checkOutput($sformatf("colour%0d_done", k - 3), bus0.done_o, 1);
        checkOutput($sformatf("colour%0d_grey", k - 3), int'(bus0.grey_o), colourGrey[k - 3]);
      end
    end
    waitFrameDone("colour_frame_done");
    for (int i = 0; i < 4; i++) mem[i] = {3{8'(i)}};

    $display("[TB] GAP=2 frame");
    doneCnt = 0;
    for (int k = 0; k <= 38; k++) begin
      @(posedge clk);
      #1 bus2.start_i = (k == 0);
      @(negedge clk);
      checkOutput($sformatf("gap_k%0d_rd", k), bus2.mem_rd_o, (k >= 1 && k <= 34 && (k - 1) % 3 == 0) ? 1 : 0);
      if (bus2.mem_rd_o) checkOutput($sformatf("gap_k%0d_addr", k), int'(bus2.mem_addr_o), (k - 1) / 3);
      checkOutput($sformatf("gap_k%0d_done", k), bus2.done_o, (k >= 3 && k <= 36 && (k - 3) % 3 == 0) ? 1 : 0);
      if (bus2.done_o) begin
        checkOutput($sformatf("gap_k%0d_grey", k), int'(bus2.grey_o), (k - 3) / 3);
        doneCnt++;
      end
      checkOutput($sformatf("gap_k%0d_busy", k), bus2.busy_o, (k >= 1 && k <= 36) ? 1 : 0);
      checkOutput($sformatf("gap_k%0d_frame_done", k), bus2.frame_done_o, (k == 36) ? 1 : 0);
    end
    checkOutput("gap_done_count", doneCnt, 12);

    $display("[TB] hold after fourth read, and hold during drain");
    for (int k = 0; k <= 22; k++) begin
      applyStimulus(k == 0 ? 1 : 0, ((k >= 5 && k <= 9) || (k >= 18 && k <= 19)) ? 1 : 0);
      if (bus0.mem_rd_o) rdAddrs.push_back(int'(bus0.mem_addr_o));
      if (bus0.done_o) greys.push_back(int'(bus0.grey_o));
      checkOutput($sformatf("hold_k%0d_done", k), bus0.done_o,
                  ((k >= 3 && k <= 6) || (k >= 12 && k <= 19)) ? 1 : 0);
      checkOutput($sformatf("hold_k%0d_frame_done", k), bus0.frame_done_o, (k == 19) ? 1 : 0);
    end
    checkOutput("hold_rd_count", rdAddrs.size(), 12);
    checkOutput("hold_done_count", greys.size(), 12);
    for (int i = 0; i < rdAddrs.size(); i++) checkOutput($sformatf("hold_rd%0d_addr", i), rdAddrs[i], i);
    for (int i = 0; i < greys.size(); i++) checkOutput($sformatf("hold_px%0d_grey", i), greys[i], i);

    $display("[TB] start ignored mid-frame and at frame end, restart afterwards");
    for (int k = 0; k <= 31; k++) begin
      applyStimulus((k == 0 || k == 5 || k == 14 || k == 16) ? 1 : 0, 0);
      checkOutput($sformatf("restart_k%0d_rd", k), bus0.mem_rd_o,
                  ((k >= 1 && k <= 12) || (k >= 17 && k <= 28)) ? 1 : 0);
      if (bus0.mem_rd_o)
        checkOutput($sformatf("restart_k%0d_addr", k), int'(bus0.mem_addr_o), (k <= 12) ? k - 1 : k - 17);
      checkOutput($sformatf("restart_k%0d_busy", k), bus0.busy_o,
                  ((k >= 1 && k <= 14) || (k >= 17 && k <= 30)) ? 1 : 0);
      checkOutput($sformatf("restart_k%0d_frame_done", k), bus0.frame_done_o, (k == 14 || k == 30) ? 1 : 0);
    end

    $display("[TB] reset pulse at pixel 6");
    for (int k = 0; k <= 9; k++) applyStimulus(k == 0 ? 1 : 0, 0);
    checkOutput("rstmid_pre_done", bus0.done_o, 1);
    checkOutput("rstmid_pre_grey", int'(bus0.grey_o), 6);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstmid_mem_rd", bus0.mem_rd_o, 0);
    checkOutput("rstmid_mem_addr", int'(bus0.mem_addr_o), 0);
    checkOutput("rstmid_grey", int'(bus0.grey_o), 0);
    checkOutput("rstmid_done", bus0.done_o, 0);
    checkOutput("rstmid_line_end", bus0.line_end_o, 0);
    checkOutput("rstmid_busy", bus0.busy_o, 0);
    checkOutput("rstmid_frame_done", bus0.frame_done_o, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    doneCnt = 0;
    fdCnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0);
      if (bus0.done_o) doneCnt++;
      if (bus0.frame_done_o) fdCnt++;
    end
    checkOutput("rstmid_quiet_done", doneCnt, 0);
    checkOutput("rstmid_quiet_frame_done", fdCnt, 0);

    doneCnt = 0;
    fdCnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k == 0 ? 1 : 0, 0);
      if (bus0.done_o) begin
        checkOutput($sformatf("rstmid_px%0d_grey", doneCnt), int'(bus0.grey_o), doneCnt);
        doneCnt++;
      end
      if (bus0.frame_done_o) fdCnt++;
    end
    checkOutput("rstmid_frame_px_count", doneCnt, 12);
    checkOutput("rstmid_frame_done_count", fdCnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
